// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave over a word SRAM with
// programmable wait states, byte-strobed writes and out-of-range fault reporting.
module dmem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d, ready_q, ready_d, error_q, error_d, we;
  logic [31:0] sram [DEPTH];
  logic [AW-1:0] idx;
  logic        in_range;
  logic        unused_ok;
  assign idx       = addr_q[AW+1:2];
  assign in_range  = addr_q[31:AW+2] == '0;
  assign unused_ok = ^{instr_q, addr_q[1:0]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    ready_d = 1'b0;
    rdata_d = '0;
    error_d = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: if (mem_valid) begin
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        instr_d = mem_instr;
        cnt_d   = 4'(LATENCY);
        state_d = WAIT;
      end
      WAIT: if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = RESP;
        ready_d = 1'b1;
        error_d = !in_range;
        we      = in_range && wstrb_q != '0;
        rdata_d = (in_range && wstrb_q == '0) ? sram[idx] : '0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end
  // Storage is never cleared; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && we)
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) sram[idx][8*b +: 8] <= wdata_q[8*b +: 8];
  end
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign mem_error = error_q;
endmodule
